antirrebote_botones: RTL and testbench
======================================

ANTIRREBOTE_BOTONES -- requirements
Module: antirrebote_botones

Interface
REQ-001 Parameter DB_CYCLES, default 1000000, number of consecutive stable clk cycles required to accept a level change (20 ms at 50 MHz); legal range 2..2^24.
REQ-002 Port clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 Port btn_n  input  4  raw asynchronous push buttons, active-low; bit0=A load, bit1=B load, bit2=op load, bit3=result load.
REQ-005 Port btn_lvl_n  output  4  debounced button level, active-low, registered.
REQ-006 Port btn_pulse_n  output  4  press strobe, active-low, exactly one clk cycle per accepted press, registered; drives the downstream enA/enB/enO/enS load enables.

Function
REQ-007 Each bit of btn_n SHALL pass through a 2-flop synchronizer; both flops reset to 1; no logic reads btn_n before the second flop.
REQ-008 The four channels SHALL be fully independent; each has its own FSM and counter of width clog2(DB_CYCLES).
REQ-009 Channel FSM states SHALL be REL (stable released), PRESS_CHK (candidate press), PRS (stable pressed), REL_CHK (candidate release).
REQ-010 REL -> PRESS_CHK when synchronized input = 0, counter loaded with 1; otherwise stay, counter = 0.
REQ-011 PRESS_CHK: synchronized input = 1 -> REL, counter = 0; input = 0 and counter < DB_CYCLES-1 -> stay, counter + 1; input = 0 and counter = DB_CYCLES-1 -> PRS, counter = 0.
REQ-012 PRS -> REL_CHK when synchronized input = 1, counter loaded with 1; REL_CHK mirrors REQ-011 with polarities swapped, exiting to REL on acceptance and back to PRS on a glitch.
REQ-013 btn_lvl_n SHALL be 0 exactly while the FSM is in PRS or REL_CHK, and 1 in REL or PRESS_CHK.
REQ-014 btn_pulse_n SHALL be 0 for exactly the one cycle following the PRESS_CHK -> PRS transition, coincident with the falling edge of btn_lvl_n; release SHALL NOT generate a pulse.
REQ-015 Latency: a clean input level change SHALL appear on btn_lvl_n after the (DB_CYCLES+2)th rising edge following the change.
REQ-016 Any bounce shorter than DB_CYCLES cycles SHALL be discarded with no change on either output.
REQ-017 A button held indefinitely SHALL produce a single pulse; a new pulse requires an accepted release first.
REQ-018 Simultaneous presses on several channels SHALL produce simultaneous pulses; no arbitration or priority.
REQ-019 Counter SHALL never exceed DB_CYCLES-1 and SHALL never wrap.

Reset
REQ-020 While rst_n = 0: synchronizers = 1, all FSMs = REL, counters = 0, btn_lvl_n = 4'b1111, btn_pulse_n = 4'b1111.
REQ-021 Reset assertion mid-debounce SHALL abandon the check immediately with no pulse.
REQ-022 A button held low across reset release SHALL be treated as a new press: one pulse after DB_CYCLES+2 edges.

Verification (DB_CYCLES = 4)
REQ-023 Reset, btn_n = 1111 -> btn_lvl_n = 1111, btn_pulse_n = 1111 for 20 cycles.
REQ-024 btn_n[0] 1 -> 0 held 30 cycles -> btn_lvl_n[0] = 0 after 6th edge; btn_pulse_n = 1110 for one cycle only.
REQ-025 btn_n[1] low 3 cycles then high, repeated 5 times -> no change on btn_lvl_n[1], no pulse.
REQ-026 btn_n = 0000 at once, held -> one simultaneous btn_pulse_n = 0000 cycle; release with bounces of 2 cycles, then clean high -> btn_lvl_n returns 1111 with no pulse.
REQ-027 rst_n = 0 at cycle 3 of PRESS_CHK on bit 2 -> no pulse; rst_n = 1 with btn_n[2] still 0 -> one pulse 6 edges after release of reset.
REQ-028 Press, release, press on bit 3 each held 10 cycles -> exactly two pulses, 20 cycles apart.

Source files
------------

// File: rtl/antirrebote_botones_if.sv
// Button bundle between the raw push-button pins and the debouncer.
// The master drives the raw active-low buttons; the slave returns debounced level and press strobe.
interface antirrebote_botones_if;
  logic [3:0] btn_n;
  logic [3:0] btn_lvl_n;
  logic [3:0] btn_pulse_n;

  modport master (
    output btn_n,
    input  btn_lvl_n,
    input  btn_pulse_n
  );

  modport slave (
    input  btn_n,
    output btn_lvl_n,
    output btn_pulse_n
  );
endinterface

// File: rtl/antirrebote_botones.sv
// Four independent push-button debouncers with a 2-flop synchronizer per input.
// Each channel emits a registered debounced level and a one-cycle press strobe (both active-low).
module antirrebote_botones #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input logic                  clk,
  input logic                  rst_n,
  antirrebote_botones_if.slave bus
);

  localparam int unsigned   CW       = (DB_CYCLES > 32'd1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    REL       = 2'd0,
    PRESS_CHK = 2'd1,
    PRS       = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  logic [3:0] sync1_r;
  logic [3:0] sync2_r;

  // Two-stage synchronizer; idles released so reset never looks like a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 4'b1111;
      sync2_r <= 4'b1111;
    end else begin
      sync1_r <= bus.btn_n;
      sync2_r <= sync1_r;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch
    state_t        st_r;
    state_t        st_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          lvl_r;
    logic          lvl_s;
    logic          pulse_r;
    logic          pulse_s;
    logic          in_s;

    assign in_s = sync2_r[g];

    // Next-state, counter and output decode; outputs follow the next state so they land with the transition
    always_comb begin
      st_s    = st_r;
      cnt_s   = cnt_r;
      lvl_s   = 1'b1;
      pulse_s = 1'b1;
      case (st_r)
        REL: begin
          if (!in_s) begin
            st_s  = PRESS_CHK;
            cnt_s = CNT_ONE;
          end else begin
            cnt_s = CNT_ZERO;
          end
        end
        PRESS_CHK: begin
          if (in_s) begin
            st_s  = REL;
            cnt_s = CNT_ZERO;
          end else if (cnt_r < CNT_LAST) begin
            cnt_s = cnt_r + CNT_ONE;
          end else begin
            st_s  = PRS;
            cnt_s = CNT_ZERO;
          end
        end
        PRS: begin
          if (in_s) begin
            st_s  = REL_CHK;
            cnt_s = CNT_ONE;
          end else begin
            cnt_s = CNT_ZERO;
          end
        end
        REL_CHK: begin
          if (!in_s) begin
            st_s  = PRS;
            cnt_s = CNT_ZERO;
          end else if (cnt_r < CNT_LAST) begin
            cnt_s = cnt_r + CNT_ONE;
          end else begin
            st_s  = REL;
            cnt_s = CNT_ZERO;
          end
        end
        default: begin
          st_s  = REL;
          cnt_s = CNT_ZERO;
        end
      endcase

      if ((st_s == PRS) || (st_s == REL_CHK)) begin
        lvl_s = 1'b0;
      end else begin
        lvl_s = 1'b1;
      end

      // Only an accepted press strobes; accepted releases stay silent
      if ((st_r == PRESS_CHK) && (st_s == PRS)) begin
        pulse_s = 1'b0;
      end else begin
        pulse_s = 1'b1;
      end
    end

    // Channel state, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_r    <= REL;
        cnt_r   <= CNT_ZERO;
        lvl_r   <= 1'b1;
        pulse_r <= 1'b1;
      end else begin
        st_r    <= st_s;
        cnt_r   <= cnt_s;
        lvl_r   <= lvl_s;
        pulse_r <= pulse_s;
      end
    end

    assign bus.btn_lvl_n[g]   = lvl_r;
    assign bus.btn_pulse_n[g] = pulse_r;
  end

endmodule

// File: tb/tb_antirrebote_botones.sv
// Randomized and directed bench for antirrebote_botones with DB_CYCLES = 4.
// A delay-line plus run-length reference model feeds a scoreboard queue checked every cycle.
module tb_antirrebote_botones;

  localparam int unsigned DB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  antirrebote_botones_if bus ();

  antirrebote_botones #(.DB_CYCLES(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] pulse;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb_q[$];

  // Reference model: input seen two edges late, level flips after DB consecutive differing samples
  logic [3:0] m_lvl;
  logic [3:0] h1;
  logic [3:0] h2;
  int         m_run[4];

  int pulse_cnt[4];
  int pulse_cyc[4][$];

  function automatic void check(string name, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %b required %b", name, cyc, act, req);
    end
  endfunction

  function automatic void check_int(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endfunction

  function automatic void model_reset();
    m_lvl = 4'b1111;
    h1    = 4'b1111;
    h2    = 4'b1111;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    sb_q.delete();
  endfunction

  function automatic exp_t model_step(logic [3:0] raw);
    exp_t       e;
    logic [3:0] d;
    d       = h2;
    h2      = h1;
    h1      = raw;
    e.pulse = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      if (d[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == int'(DB)) begin
          m_lvl[i] = d[i];
          m_run[i] = 0;
          if (!d[i]) e.pulse[i] = 1'b0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    e.lvl = m_lvl;
    return e;
  endfunction

  function automatic void clear_pulses();
    for (int i = 0; i < 4; i++) begin
      pulse_cnt[i] = 0;
      pulse_cyc[i].delete();
    end
  endfunction

  function automatic void record_pulses(logic [3:0] p);
    for (int i = 0; i < 4; i++) begin
      if (!p[i]) begin
        pulse_cnt[i]++;
        pulse_cyc[i].push_back(cyc);
      end
    end
  endfunction

  function automatic void monitor_step();
    exp_t e;
    if (!rst_n) begin
      check("reset_outputs", {bus.btn_lvl_n, bus.btn_pulse_n}, 8'hFF);
    end else if (sb_q.size() == 0) begin
      check_int("scoreboard_underflow", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check("lvl_pulse", {bus.btn_lvl_n, bus.btn_pulse_n}, {e.lvl, e.pulse});
      record_pulses(bus.btn_pulse_n);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model produces the expected post-edge outputs for each active edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        sb_q.push_back(model_step(bus.btn_n));
  end

  // Monitor compares on the falling edge, away from the active edge
  always @(negedge clk) monitor_step();

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int c0;
  int c1;

  initial begin
    bus.btn_n = 4'b1111;
    clear_pulses();
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check_int("idle_no_pulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 0);

    // Single clean press on bit 0
    clear_pulses();
    bus.btn_n = 4'b1110;
    c0 = cyc;
    tick(30);
    bus.btn_n = 4'b1111;
    tick(12);
    check_int("b0_pulse_count", pulse_cnt[0], 1);
    if (pulse_cnt[0] == 1) check_int("b0_latency", pulse_cyc[0][0] - c0, 6);
    check_int("b0_other_pulses", pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 0);

    // Short bounces on bit 1 are discarded
    clear_pulses();
    repeat (5) begin
      bus.btn_n = 4'b1101;
      tick(3);
      bus.btn_n = 4'b1111;
      tick(3);
    end
    tick(8);
    check_int("b1_bounce_no_pulse", pulse_cnt[1], 0);

    // All four at once, then a bouncy release
    clear_pulses();
    bus.btn_n = 4'b0000;
    tick(12);
    repeat (2) begin
      bus.btn_n = 4'b1111;
      tick(2);
      bus.btn_n = 4'b0000;
      tick(2);
    end
    bus.btn_n = 4'b1111;
    tick(12);
    for (int i = 0; i < 4; i++) check_int("all_pulse_count", pulse_cnt[i], 1);
    if (pulse_cnt[0] == 1 && pulse_cnt[3] == 1) check_int("all_simultaneous", pulse_cyc[3][0], pulse_cyc[0][0]);
    check("all_released", {bus.btn_lvl_n, bus.btn_pulse_n}, 8'hFF);

    // Reset in the middle of a press check on bit 2, button still held afterwards
    clear_pulses();
    bus.btn_n = 4'b1011;
    tick(5);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    c1 = cyc;
    tick(12);
    check_int("b2_reset_pulse_count", pulse_cnt[2], 1);
    if (pulse_cnt[2] == 1) check_int("b2_reset_latency", pulse_cyc[2][0] - c1, 6);
    bus.btn_n = 4'b1111;
    tick(12);

    // Press, release, press on bit 3
    clear_pulses();
    bus.btn_n = 4'b0111;
    tick(10);
    bus.btn_n = 4'b1111;
    tick(10);
    bus.btn_n = 4'b0111;
    tick(10);
    bus.btn_n = 4'b1111;
    tick(12);
    check_int("b3_two_pulses", pulse_cnt[3], 2);
    if (pulse_cnt[3] == 2) check_int("b3_spacing", pulse_cyc[3][1] - pulse_cyc[3][0], 20);

    // Random button activity with occasional resets
    repeat (300) begin
      bus.btn_n = 4'($urandom_range(0, 15));
      tick($urandom_range(1, 8));
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
    end
    bus.btn_n = 4'b1111;
    tick(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
